// File: rtl/fft_pkg.sv
// Shared types and helpers for the in-place radix-2 FFT datapath.
package fft_pkg;

  localparam int unsigned DW_DEFAULT  = 16;
  localparam int unsigned BITREV_MAXW = 16;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_UNLOAD  = 2'd2
  } state_e;

  typedef struct packed {
    logic signed [DW_DEFAULT-1:0] re;
    logic signed [DW_DEFAULT-1:0] im;
  } cplx_t;

  // Reverse the low l_max bits of x; upper bits of the result are zero.
  function automatic logic [BITREV_MAXW-1:0] bitrev(input logic [BITREV_MAXW-1:0] x,
                                                   input int unsigned l_max);
    logic [BITREV_MAXW-1:0] r;
    logic [BITREV_MAXW-1:0] y;
    r = '0;
    y = x;
    for (int unsigned i = 0; i < BITREV_MAXW; i++) begin
      if (i < l_max) begin
        r = {r[BITREV_MAXW-2:0], y[0]};
        y = {1'b0, y[BITREV_MAXW-1:1]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_ram_bank.sv
// N-word complex storage: two synchronous read ports with hold, two write ports,
// read-before-write, port B wins a same-address write collision.
module fft_ram_bank
  import fft_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re_a,
  input  logic [AW-1:0] ra_a,
  output cplx_t         rd_a,
  input  logic          re_b,
  input  logic [AW-1:0] ra_b,
  output cplx_t         rd_b,
  input  logic          we_a,
  input  logic [AW-1:0] wa_a,
  input  cplx_t         wd_a,
  input  logic          we_b,
  input  logic [AW-1:0] wa_b,
  input  cplx_t         wd_b
);

  cplx_t mem [N];
  cplx_t rd_a_q, rd_a_d;
  cplx_t rd_b_q, rd_b_d;

  // Read registers load only when enabled, otherwise hold.
  always_comb begin
    rd_a_d = rd_a_q;
    rd_b_d = rd_b_q;
    if (re_a) rd_a_d = mem[ra_a];
    if (re_b) rd_b_d = mem[ra_b];
  end

  // Storage is not reset; the later B assignment wins on a collision.
  always_ff @(posedge clk) begin
    if (we_a) mem[wa_a] <= wd_a;
    if (we_b) mem[wa_b] <= wd_b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign rd_a = rd_a_q;
  assign rd_b = rd_b_q;

endmodule

// File: rtl/fft_data_ram.sv
// FFT data RAM and stream adapter: load frame, serve butterfly traffic, unload.
// Define FFT_DATA_RAM_BITREV_EN to store the input frame in bit-reversed order.
module fft_data_ram
  import fft_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned L_MAX = 3,
  parameter int unsigned DW    = DW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_re,
  input  logic [DW-1:0]    in_im,
  output logic             initial_flag,
  input  logic             rd_en,
  input  logic [L_MAX-1:0] rd_add1,
  input  logic [L_MAX-1:0] rd_add2,
  output logic [DW-1:0]    rd_a_re,
  output logic [DW-1:0]    rd_a_im,
  output logic [DW-1:0]    rd_b_re,
  output logic [DW-1:0]    rd_b_im,
  input  logic             wr_en,
  input  logic [L_MAX-1:0] wr_add1,
  input  logic [L_MAX-1:0] wr_add2,
  input  logic [DW-1:0]    wr_a_re,
  input  logic [DW-1:0]    wr_a_im,
  input  logic [DW-1:0]    wr_b_re,
  input  logic [DW-1:0]    wr_b_im,
  input  logic             wd_finish,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_re,
  output logic [DW-1:0]    out_im,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned UW = L_MAX + 1;

  state_e           state_q, state_d;
  logic [L_MAX-1:0] cnt_q, cnt_d;
  logic [UW-1:0]    ua_q, ua_d;
  logic             s1_v_q, s1_v_d;
  logic             s1_last_q, s1_last_d;
  cplx_t            skid_q, skid_d;
  logic             skid_v_q, skid_v_d;
  logic             skid_last_q, skid_last_d;
  cplx_t            out_q, out_d;
  logic             out_v_q, out_v_d;
  logic             out_last_q, out_last_d;
  logic             in_ready_q, in_ready_d;
  logic             init_q, init_d;
  logic             busy_q, busy_d;

  logic             load_acc, cmp_rd, cmp_wr, issue, take, out_free;
  logic [L_MAX-1:0] load_addr;
  logic             re_a, re_b, we_a, we_b;
  logic [L_MAX-1:0] ra_b, wa_a;
  cplx_t            wd_a, wd_b, bank_rd_a, bank_rd_b;

`ifdef FFT_DATA_RAM_BITREV_EN
  assign load_addr = L_MAX'(bitrev(BITREV_MAXW'(cnt_q), L_MAX));
`else
  assign load_addr = cnt_q;
`endif

  // Port muxing between load, butterfly and unload traffic.
  always_comb begin
    load_acc = (state_q == ST_LOAD) && in_valid && in_ready_q;
    cmp_rd   = (state_q == ST_COMPUTE) && rd_en;
    cmp_wr   = (state_q == ST_COMPUTE) && wr_en;
    take     = s1_v_q && !skid_v_q;
    out_free = !out_v_q || out_ready;
    issue    = (state_q == ST_UNLOAD) && (ua_q < UW'(N)) && (!s1_v_q || take);

    re_a  = cmp_rd;
    re_b  = cmp_rd || issue;
    ra_b  = (state_q == ST_COMPUTE) ? rd_add2 : ua_q[L_MAX-1:0];
    we_a  = load_acc || cmp_wr;
    we_b  = cmp_wr;
    wa_a  = (state_q == ST_LOAD) ? load_addr : wr_add1;
    wd_a  = (state_q == ST_LOAD) ? '{re: in_re, im: in_im} : '{re: wr_a_re, im: wr_a_im};
    wd_b  = '{re: wr_b_re, im: wr_b_im};
  end

  fft_ram_bank #(.N(N), .AW(L_MAX)) u_bank (
    .clk  (clk),
    .rst  (rst),
    .re_a (re_a),
    .ra_a (rd_add1),
    .rd_a (bank_rd_a),
    .re_b (re_b),
    .ra_b (ra_b),
    .rd_b (bank_rd_b),
    .we_a (we_a),
    .wa_a (wa_a),
    .wd_a (wd_a),
    .we_b (we_b),
    .wa_b (wr_add2),
    .wd_b (wd_b)
  );

  // Next-state, counters and the read-stage / output / skid pipeline.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ua_d        = ua_q;
    s1_v_d      = s1_v_q;
    s1_last_d   = s1_last_q;
    skid_d      = skid_q;
    skid_v_d    = skid_v_q;
    skid_last_d = skid_last_q;
    out_d       = out_q;
    out_v_d     = out_v_q;
    out_last_d  = out_last_q;
    in_ready_d  = in_ready_q;
    init_d      = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      ST_LOAD: begin
        if (load_acc) begin
          cnt_d = cnt_q + L_MAX'(1);
          if (cnt_q == L_MAX'(N - 1)) begin
            state_d    = ST_COMPUTE;
            in_ready_d = 1'b0;
            init_d     = 1'b1;
            busy_d     = 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        if (wd_finish) begin
          state_d = ST_UNLOAD;
          ua_d    = '0;
        end
      end
      ST_UNLOAD: begin
        if (issue) ua_d = ua_q + UW'(1);
        if (out_v_q && out_ready && out_last_q) begin
          state_d    = ST_LOAD;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
          ua_d       = '0;
        end
      end
      default: state_d = ST_LOAD;
    endcase

    if (take) s1_v_d = 1'b0;
    if (issue) begin
      s1_v_d    = 1'b1;
      s1_last_d = (ua_q == UW'(N - 1));
    end

    // Skid absorbs the one beat already in flight when the output stalls.
    if (out_free) begin
      if (skid_v_q) begin
        out_d      = skid_q;
        out_last_d = skid_last_q;
        out_v_d    = 1'b1;
        skid_v_d   = 1'b0;
      end else begin
        out_v_d    = take;
        out_last_d = take ? s1_last_q : 1'b0;
        if (take) out_d = bank_rd_b;
      end
    end else if (take) begin
      skid_d      = bank_rd_b;
      skid_last_d = s1_last_q;
      skid_v_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      ua_q        <= '0;
      s1_v_q      <= 1'b0;
      s1_last_q   <= 1'b0;
      skid_q      <= '0;
      skid_v_q    <= 1'b0;
      skid_last_q <= 1'b0;
      out_q       <= '0;
      out_v_q     <= 1'b0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      init_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ua_q        <= ua_d;
      s1_v_q      <= s1_v_d;
      s1_last_q   <= s1_last_d;
      skid_q      <= skid_d;
      skid_v_q    <= skid_v_d;
      skid_last_q <= skid_last_d;
      out_q       <= out_d;
      out_v_q     <= out_v_d;
      out_last_q  <= out_last_d;
      in_ready_q  <= in_ready_d;
      init_q      <= init_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign initial_flag = init_q;
  assign busy         = busy_q;
  assign out_valid    = out_v_q;
  assign out_last     = out_last_q;
  assign out_re       = out_q.re;
  assign out_im       = out_q.im;
  assign rd_a_re      = bank_rd_a.re;
  assign rd_a_im      = bank_rd_a.im;
  assign rd_b_re      = bank_rd_b.re;
  assign rd_b_im      = bank_rd_b.im;

endmodule

// File: tb/tb_fft_data_ram.sv
// Self-checking bench for fft_data_ram; follows FFT_DATA_RAM_BITREV_EN like the RTL.
module tb_fft_data_ram;

  localparam int N  = 8;
  localparam int L  = 3;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_re, in_im;
  logic          initial_flag;
  logic          rd_en;
  logic [L-1:0]  rd_add1, rd_add2;
  logic [DW-1:0] rd_a_re, rd_a_im, rd_b_re, rd_b_im;
  logic          wr_en;
  logic [L-1:0]  wr_add1, wr_add2;
  logic [DW-1:0] wr_a_re, wr_a_im, wr_b_re, wr_b_im;
  logic          wd_finish;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_re, out_im;
  logic          out_last, busy;

  fft_data_ram #(.N(N), .L_MAX(L), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .initial_flag(initial_flag),
    .rd_en(rd_en), .rd_add1(rd_add1), .rd_add2(rd_add2),
    .rd_a_re(rd_a_re), .rd_a_im(rd_a_im), .rd_b_re(rd_b_re), .rd_b_im(rd_b_im),
    .wr_en(wr_en), .wr_add1(wr_add1), .wr_add2(wr_add2),
    .wr_a_re(wr_a_re), .wr_a_im(wr_a_im), .wr_b_re(wr_b_re), .wr_b_im(wr_b_im),
    .wd_finish(wd_finish),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: memory image plus the expected butterfly read registers.
  logic [DW-1:0] m_re [N];
  logic [DW-1:0] m_im [N];
  logic [DW-1:0] e_ra_re, e_ra_im, e_rb_re, e_rb_im;
  bit            rd_known;

  typedef struct {
    int            a1;
    int            a2;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
  } rd_vec_t;
  rd_vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample index k lands at this address.
  function automatic int map_addr(input int k);
`ifdef FFT_DATA_RAM_BITREV_EN
    int r = 0;
    for (int i = 0; i < L; i++)
      if (((k >> i) & 1) == 1) r += 1 << (L - 1 - i);
    return r;
`else
    return k;
`endif
  endfunction

  task automatic clear_inputs();
    in_valid = 0; in_re = '0; in_im = '0;
    rd_en = 0; rd_add1 = '0; rd_add2 = '0;
    wr_en = 0; wr_add1 = '0; wr_add2 = '0;
    wr_a_re = '0; wr_a_im = '0; wr_b_re = '0; wr_b_im = '0;
    wd_finish = 0; out_ready = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_initial_flag"}, 32'(initial_flag), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_out_data"}, {out_re, out_im}, 32'd0);
    chk({tag, "_rd_a"}, {rd_a_re, rd_a_im}, 32'd0);
    chk({tag, "_rd_b"}, {rd_b_re, rd_b_im}, 32'd0);
  endtask

  task automatic apply_reset(input string tag);
    clear_inputs();
    rst = 1'b0;
    tick();
    tick();
    check_reset_outputs(tag);
    e_ra_re = '0; e_ra_im = '0; e_rb_re = '0; e_rb_im = '0;
    rd_known = 1;
    rst = 1'b1;
    tick();
  endtask

  // Load nbeats samples with random gaps; noise drives strobes that must be ignored.
  task automatic load_frame(input int nbeats, input bit ramp, input bit noise);
    for (int k = 0; k < nbeats; k++) begin
      int gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        if (noise) begin
          rd_en = 1; rd_add1 = L'($urandom()); rd_add2 = L'($urandom());
          wr_en = 1; wr_add1 = L'($urandom()); wr_add2 = L'($urandom());
          wr_a_re = DW'($urandom()); wr_b_re = DW'($urandom());
          wd_finish = 1;
        end
        tick();
        clear_inputs();
        chk("load_gap_busy", 32'(busy), 32'd0);
      end
      chk("load_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1;
      in_re = ramp ? DW'(k) : DW'($urandom());
      in_im = ramp ? '0 : DW'($urandom());
      if (noise) begin
        wr_en = 1; wr_add1 = L'(map_addr(k)); wr_add2 = L'(map_addr(k));
        wr_a_re = 16'hDEAD; wr_a_im = 16'hBEEF; wr_b_re = 16'hCAFE; wr_b_im = 16'hF00D;
        rd_en = 1; rd_add1 = L'(map_addr(k)); rd_add2 = '0;
      end
      m_re[map_addr(k)] = in_re;
      m_im[map_addr(k)] = in_im;
      tick();
      clear_inputs();
      if (k == N - 1) begin
        chk("load_done_initial_flag", 32'(initial_flag), 32'd1);
        chk("load_done_in_ready", 32'(in_ready), 32'd0);
        chk("load_done_busy", 32'(busy), 32'd1);
      end else begin
        chk("load_initial_flag_low", 32'(initial_flag), 32'd0);
      end
    end
    if (nbeats == N) begin
      tick();
      chk("initial_flag_pulse_end", 32'(initial_flag), 32'd0);
      chk("compute_busy", 32'(busy), 32'd1);
      if (noise && rd_known) begin
        chk("load_rd_a_held", {rd_a_re, rd_a_im}, {e_ra_re, e_ra_im});
        chk("load_rd_b_held", {rd_b_re, rd_b_im}, {e_rb_re, e_rb_im});
      end
    end
  endtask

  // One COMPUTE cycle of butterfly traffic, checked against the model.
  task automatic do_op(input bit rd, input int ra1, input int ra2, input bit wr,
                       input int wa1, input int wa2,
                       input logic [DW-1:0] are, input logic [DW-1:0] aim,
                       input logic [DW-1:0] bre, input logic [DW-1:0] bim, input bit inv);
    chk("compute_in_ready", 32'(in_ready), 32'd0);
    rd_en = rd; rd_add1 = L'(ra1); rd_add2 = L'(ra2);
    wr_en = wr; wr_add1 = L'(wa1); wr_add2 = L'(wa2);
    wr_a_re = are; wr_a_im = aim; wr_b_re = bre; wr_b_im = bim;
    in_valid = inv; in_re = DW'($urandom()); in_im = DW'($urandom());
    if (rd) begin
      e_ra_re = m_re[ra1]; e_ra_im = m_im[ra1];
      e_rb_re = m_re[ra2]; e_rb_im = m_im[ra2];
      rd_known = 1;
    end
    if (wr) begin
      m_re[wa1] = are; m_im[wa1] = aim;
      m_re[wa2] = bre; m_im[wa2] = bim;
    end
    tick();
    clear_inputs();
    if (rd_known) begin
      chk("rd_a", {rd_a_re, rd_a_im}, {e_ra_re, e_ra_im});
      chk("rd_b", {rd_b_re, rd_b_im}, {e_rb_re, e_rb_im});
    end
  endtask

  task automatic random_ops(input int n);
    for (int i = 0; i < n; i++)
      do_op((i == 0) ? 1'b1 : 1'(($urandom() & 1)),
            int'($urandom_range(0, N-1)), int'($urandom_range(0, N-1)),
            1'(($urandom() & 1)), int'($urandom_range(0, N-1)), int'($urandom_range(0, N-1)),
            DW'($urandom()), DW'($urandom()), DW'($urandom()), DW'($urandom()),
            1'(($urandom() & 3) == 0));
  endtask

  // mode 0: ready 1,0,0,1; mode 1: always ready; mode 2: random. stop_after>0 aborts early.
  task automatic unload(input int mode, input int stop_after);
    int idx = 0;
    int p = 0;
    int budget = 200;
    bit rdy;
    wd_finish = 1;
    tick();
    wd_finish = 0;
    chk("unload_t0_valid", 32'(out_valid), 32'd0);
    chk("unload_busy", 32'(busy), 32'd1);
    tick();
    chk("unload_t1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("unload_t2_valid", 32'(out_valid), 32'd1);
    while (idx < N && budget > 0) begin
      if (mode == 1) chk("unload_stream_valid", 32'(out_valid), 32'd1);
      if (out_valid) begin
        chk("unload_data", {out_re, out_im}, {m_re[idx], m_im[idx]});
        chk("unload_last", 32'(out_last), 32'(idx == N - 1));
      end
      case (mode)
        0: rdy = (p % 4 == 0) || (p % 4 == 3);
        1: rdy = 1'b1;
        default: rdy = 1'($urandom() & 1);
      endcase
      p++;
      out_ready = rdy;
      if (out_valid && rdy) idx++;
      tick();
      out_ready = 0;
      budget--;
      if (stop_after > 0 && idx == stop_after) return;
    end
    if (budget == 0) chk("unload_timeout", 32'(idx), 32'(N));
    chk("post_unload_valid", 32'(out_valid), 32'd0);
    chk("post_unload_busy", 32'(busy), 32'd0);
    chk("post_unload_in_ready", 32'(in_ready), 32'd1);
    chk("post_unload_last", 32'(out_last), 32'd0);
    rd_known = 0;
  endtask

  initial begin
    clear_inputs();
    rd_known = 1;
    apply_reset("reset");

    // Frame A: ramp load with ignored strobes, table reads, butterfly corner cases.
    load_frame(N, 1'b1, 1'b1);
    tbl[0] = '{0, 4, DW'(map_addr(0)), DW'(map_addr(4))};
    tbl[1] = '{1, 4, DW'(map_addr(1)), DW'(map_addr(4))};
    tbl[2] = '{2, 6, DW'(map_addr(2)), DW'(map_addr(6))};
    tbl[3] = '{7, 3, DW'(map_addr(7)), DW'(map_addr(3))};
    tbl[4] = '{5, 5, DW'(map_addr(5)), DW'(map_addr(5))};
    tbl[5] = '{6, 1, DW'(map_addr(6)), DW'(map_addr(1))};
    for (int i = 0; i < 6; i++) begin
      rd_en = 1; rd_add1 = L'(tbl[i].a1); rd_add2 = L'(tbl[i].a2);
      tick();
      clear_inputs();
      chk("tbl_rd_a_re", 32'(rd_a_re), 32'(tbl[i].ea));
      chk("tbl_rd_b_re", 32'(rd_b_re), 32'(tbl[i].eb));
      chk("tbl_rd_im", {rd_a_im, rd_b_im}, 32'd0);
      rd_add1 = L'(tbl[i].a2); rd_add2 = L'(tbl[i].a1);
      tick();
      clear_inputs();
      chk("tbl_hold", {rd_a_re, rd_b_re}, {tbl[i].ea, tbl[i].eb});
      e_ra_re = tbl[i].ea; e_rb_re = tbl[i].eb; e_ra_im = '0; e_rb_im = '0;
    end

    do_op(1, 2, 3, 1, 2, 3, 16'h0064, 16'hFF9C, 16'hFFFB, 16'h0007, 0);
    chk("bfly_same_cycle_old", 32'(rd_a_re), 32'(map_addr(2)));
    do_op(1, 2, 3, 0, 0, 0, '0, '0, '0, '0, 1);
    chk("bfly_new_a", {rd_a_re, rd_a_im}, 32'h0064FF9C);
    chk("bfly_new_b", {rd_b_re, rd_b_im}, 32'hFFFB0007);
    do_op(0, 0, 0, 1, 5, 5, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 1);
    do_op(1, 5, 5, 0, 0, 0, '0, '0, '0, '0, 0);
    chk("bfly_collision_b_wins", {rd_a_re, rd_a_im}, 32'h00330044);
    random_ops(40);
    unload(0, 0);

    // Frame B: reset after 5 beats, then a full random frame at full throughput.
    load_frame(5, 1'b0, 1'b0);
    apply_reset("reset_mid_load");
    load_frame(N, 1'b0, 1'b1);
    random_ops(20);
    unload(1, 0);

    // Frame C: reset mid-unload, then a fresh frame with random backpressure.
    load_frame(N, 1'b0, 1'b0);
    random_ops(10);
    unload(2, 3);
    apply_reset("reset_mid_unload");
    load_frame(N, 1'b0, 1'b1);
    random_ops(30);
    unload(2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
